// File: rtl/pe_mp_db_if.sv
// Bundle of the pe_mp_db operand, weight-chain and result signals.
// master drives the PE inputs; slave is the PE side.
interface pe_mp_db_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PSUM_W = 3 * DATA_W
);
    logic              pe_enable;
    logic [1:0]        mode;
    logic              is_signed;
    logic              in_valid;
    logic [DATA_W-1:0] act_in;
    logic [PSUM_W-1:0] psum_in;
    logic              w_load;
    logic [DATA_W-1:0] w_in;
    logic              w_swap;
    logic              clr_sat;
    logic [DATA_W-1:0] act_out;
    logic              act_valid_out;
    logic [PSUM_W-1:0] psum_out;
    logic              psum_valid_out;
    logic [DATA_W-1:0] w_out;
    logic              w_load_out;
    logic              sat_flag;

    modport master (
        output pe_enable, mode, is_signed, in_valid, act_in, psum_in,
               w_load, w_in, w_swap, clr_sat,
        input  act_out, act_valid_out, psum_out, psum_valid_out,
               w_out, w_load_out, sat_flag
    );

    modport slave (
        input  pe_enable, mode, is_signed, in_valid, act_in, psum_in,
               w_load, w_in, w_swap, clr_sat,
        output act_out, act_valid_out, psum_out, psum_valid_out,
               w_out, w_load_out, sat_flag
    );
endinterface

// File: rtl/pe_mp_db.sv
// Multi-precision, double-buffered, weight-stationary systolic PE.
// Define PE_SAT_EN to saturate the accumulation and implement sat_flag; otherwise it wraps.
module pe_mp_db #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PSUM_W = 3 * DATA_W
) (
    input  logic       clk,
    input  logic       reset,
    pe_mp_db_if.slave  bus
);
    // Two guard bits hold the full sum so overflow can be detected before truncation.
    localparam int unsigned EXT_W = PSUM_W + 2;

    logic [DATA_W-1:0] act_q, act_d;
    logic              act_valid_q, act_valid_d;
    logic [PSUM_W-1:0] psum_q, psum_d;
    logic              psum_valid_q, psum_valid_d;
    logic [DATA_W-1:0] w_out_q, w_out_d;
    logic              w_load_out_q, w_load_out_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] active_q, active_d;

    logic signed [EXT_W-1:0] lanes_sum;
    logic signed [EXT_W-1:0] psum_ext;
    logic signed [EXT_W-1:0] total;
    logic [PSUM_W-1:0]       psum_sum;

    for (genvar m = 0; m < 3; m++) begin : g_mode
        localparam int unsigned LANES = 1 << m;
        localparam int unsigned L     = DATA_W >> m;
        logic signed [EXT_W-1:0] lane_sum;
        logic [L-1:0]            a_l, w_l;
        logic signed [L:0]       a_x, w_x;
        logic signed [2*L+1:0]   prod;

        always_comb begin
            lane_sum = '0;
            a_l      = '0;
            w_l      = '0;
            a_x      = '0;
            w_x      = '0;
            prod     = '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                a_l      = bus.act_in[k*L +: L];
                w_l      = active_q[k*L +: L];
                a_x      = signed'({bus.is_signed & a_l[L-1], a_l});
                w_x      = signed'({bus.is_signed & w_l[L-1], w_l});
                prod     = a_x * w_x;
                lane_sum = lane_sum + {{(EXT_W-2*L-2){prod[2*L+1]}}, prod};
            end
        end
    end

    always_comb begin
        case (bus.mode)
            2'd1:    lanes_sum = g_mode[1].lane_sum;
            2'd2:    lanes_sum = g_mode[2].lane_sum;
            default: lanes_sum = g_mode[0].lane_sum;
        endcase
        psum_ext = bus.is_signed ? {{2{bus.psum_in[PSUM_W-1]}}, bus.psum_in}
                                 : {2'b00, bus.psum_in};
        total    = psum_ext + lanes_sum;
    end

`ifdef PE_SAT_EN
    logic sat_q, sat_d;
    logic sat_hit;

    always_comb begin
        sat_hit  = 1'b0;
        psum_sum = total[PSUM_W-1:0];
        if (bus.is_signed) begin
            if (total[EXT_W-1] && (total[EXT_W-2:PSUM_W-1] != '1)) begin
                sat_hit  = 1'b1;
                psum_sum = {1'b1, {(PSUM_W-1){1'b0}}};
            end else if (!total[EXT_W-1] && (total[EXT_W-2:PSUM_W-1] != '0)) begin
                sat_hit  = 1'b1;
                psum_sum = {1'b0, {(PSUM_W-1){1'b1}}};
            end
        end else if (total[EXT_W-1:PSUM_W] != '0) begin
            sat_hit  = 1'b1;
            psum_sum = '1;
        end
        // A saturation in the clearing cycle keeps the flag set.
        sat_d = (bus.in_valid & sat_hit) | (sat_q & ~bus.clr_sat);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if (bus.pe_enable) begin
            sat_q <= sat_d;
        end
    end

    assign bus.sat_flag = sat_q;
`else
    logic unused_sat;

    always_comb psum_sum = total[PSUM_W-1:0];

    assign unused_sat   = ^{bus.clr_sat, total[EXT_W-1:PSUM_W]};
    assign bus.sat_flag = 1'b0;
`endif

    always_comb begin
        act_d        = bus.in_valid ? bus.act_in : act_q;
        act_valid_d  = bus.in_valid;
        psum_d       = bus.in_valid ? psum_sum : psum_q;
        psum_valid_d = bus.in_valid;
        shadow_d     = bus.w_load ? bus.w_in : shadow_q;
        w_out_d      = bus.w_load ? bus.w_in : w_out_q;
        w_load_out_d = bus.w_load;
        active_d     = bus.w_swap ? shadow_q : active_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q        <= '0;
            act_valid_q  <= 1'b0;
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
            w_out_q      <= '0;
            w_load_out_q <= 1'b0;
            shadow_q     <= '0;
            active_q     <= '0;
        end else if (bus.pe_enable) begin
            act_q        <= act_d;
            act_valid_q  <= act_valid_d;
            psum_q       <= psum_d;
            psum_valid_q <= psum_valid_d;
            w_out_q      <= w_out_d;
            w_load_out_q <= w_load_out_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    assign bus.act_out        = act_q;
    assign bus.act_valid_out  = act_valid_q;
    assign bus.psum_out       = psum_q;
    assign bus.psum_valid_out = psum_valid_q;
    assign bus.w_out          = w_out_q;
    assign bus.w_load_out     = w_load_out_q;
endmodule

// File: tb/tb_pe_mp_db.sv
// Directed self-checking bench for pe_mp_db (DATA_W=8, PSUM_W=24), either PE_SAT_EN build.
module tb_pe_mp_db;
`ifdef PE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    pe_mp_db_if #(.DATA_W(8), .PSUM_W(24)) bus ();

    pe_mp_db #(.DATA_W(8), .PSUM_W(24)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [23:0] psum, input logic pv,
                        input logic [7:0] act, input logic av,
                        input logic [7:0] wo, input logic wl);
        chk({tag, ".psum_out"}, 32'(bus.psum_out), 32'(psum));
        chk({tag, ".psum_valid"}, 32'(bus.psum_valid_out), 32'(pv));
        chk({tag, ".act_out"}, 32'(bus.act_out), 32'(act));
        chk({tag, ".act_valid"}, 32'(bus.act_valid_out), 32'(av));
        chk({tag, ".w_out"}, 32'(bus.w_out), 32'(wo));
        chk({tag, ".w_load_out"}, 32'(bus.w_load_out), 32'(wl));
    endtask

    task automatic load_weight(input logic [7:0] w);
        bus.in_valid = 1'b0;
        bus.w_load   = 1'b1;
        bus.w_in     = w;
        step();
        bus.w_load   = 1'b0;
        bus.w_swap   = 1'b1;
        step();
        bus.w_swap   = 1'b0;
    endtask

    task automatic compute(input logic [1:0] md, input logic sg,
                           input logic [7:0] act, input logic [23:0] ps);
        bus.mode      = md;
        bus.is_signed = sg;
        bus.act_in    = act;
        bus.psum_in   = ps;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset         = 1'b1;
        bus.pe_enable = 1'b0;
        bus.mode      = 2'd0;
        bus.is_signed = 1'b0;
        bus.in_valid  = 1'b0;
        bus.act_in    = '0;
        bus.psum_in   = '0;
        bus.w_load    = 1'b0;
        bus.w_in      = '0;
        bus.w_swap    = 1'b0;
        bus.clr_sat   = 1'b0;
        step();
        step();
        outs("reset", 24'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("reset.sat_flag", 32'(bus.sat_flag), 32'h0);
        reset         = 1'b0;
        bus.pe_enable = 1'b1;

        // Weight chain hop and swap
        bus.w_load = 1'b1;
        bus.w_in   = 8'hFD;
        step();
        chk("wload.w_out", 32'(bus.w_out), 32'hFD);
        chk("wload.w_load_out", 32'(bus.w_load_out), 32'h1);
        bus.w_load = 1'b0;
        bus.w_swap = 1'b1;
        step();
        bus.w_swap = 1'b0;
        chk("wswap.w_load_out", 32'(bus.w_load_out), 32'h0);
        chk("wswap.w_out_hold", 32'(bus.w_out), 32'hFD);

        // Mode 0 signed: -3*5 + 100
        compute(2'd0, 1'b1, 8'h05, 24'd100);
        outs("m0s", 24'd85, 1'b1, 8'h05, 1'b1, 8'hFD, 1'b0);
        step();
        chk("idle.psum_valid", 32'(bus.psum_valid_out), 32'h0);
        chk("idle.act_valid", 32'(bus.act_valid_out), 32'h0);
        chk("idle.psum_hold", 32'(bus.psum_out), 32'd85);
        chk("idle.act_hold", 32'(bus.act_out), 32'h05);

        // Mode 1
        load_weight(8'h32);
        compute(2'd1, 1'b0, 8'h45, 24'd0);
        chk("m1u.psum", 32'(bus.psum_out), 32'd22);
        load_weight(8'hF2);
        compute(2'd1, 1'b1, 8'h7F, 24'd0);
        chk("m1s.psum", 32'(bus.psum_out), 32'hFFFFF7);

        // Mode 2
        load_weight(8'hFF);
        compute(2'd2, 1'b1, 8'h55, 24'd0);
        chk("m2s.psum", 32'(bus.psum_out), 32'hFFFFFC);
        compute(2'd2, 1'b0, 8'h55, 24'd0);
        chk("m2u.psum", 32'(bus.psum_out), 32'd12);
        compute(2'd3, 1'b0, 8'h02, 24'd1);
        chk("m3u.psum", 32'(bus.psum_out), 32'd511);

        // Double buffer
        load_weight(8'h03);
        bus.w_load = 1'b1;
        bus.w_in   = 8'h02;
        compute(2'd0, 1'b0, 8'h04, 24'd0);
        bus.w_load = 1'b0;
        outs("db_load", 24'd12, 1'b1, 8'h04, 1'b1, 8'h02, 1'b1);
        bus.w_swap = 1'b1;
        compute(2'd0, 1'b0, 8'h04, 24'd0);
        bus.w_swap = 1'b0;
        chk("db_swap_same_cycle.psum", 32'(bus.psum_out), 32'd12);
        compute(2'd0, 1'b0, 8'h04, 24'd0);
        chk("db_after_swap.psum", 32'(bus.psum_out), 32'd8);
        bus.w_load = 1'b1;
        bus.w_in   = 8'h05;
        bus.w_swap = 1'b1;
        step();
        bus.w_load = 1'b0;
        bus.w_swap = 1'b0;
        chk("db_both.w_out", 32'(bus.w_out), 32'h05);
        compute(2'd0, 1'b0, 8'h01, 24'd0);
        chk("db_both.active", 32'(bus.psum_out), 32'd2);
        bus.w_swap = 1'b1;
        step();
        bus.w_swap = 1'b0;
        compute(2'd0, 1'b0, 8'h01, 24'd0);
        chk("db_both.shadow", 32'(bus.psum_out), 32'd5);

        // Overflow / saturation
        load_weight(8'h01);
        compute(2'd0, 1'b1, 8'h01, 24'h7FFFFF);
        chk("sat_max.psum", 32'(bus.psum_out), SAT ? 32'h7FFFFF : 32'h800000);
        chk("sat_max.flag", 32'(bus.sat_flag), SAT ? 32'h1 : 32'h0);
        compute(2'd0, 1'b1, 8'h01, 24'd0);
        chk("sat_sticky.psum", 32'(bus.psum_out), 32'd1);
        chk("sat_sticky.flag", 32'(bus.sat_flag), SAT ? 32'h1 : 32'h0);
        bus.clr_sat = 1'b1;
        compute(2'd0, 1'b1, 8'h01, 24'd0);
        chk("sat_clr.flag", 32'(bus.sat_flag), 32'h0);
        compute(2'd0, 1'b1, 8'hFF, 24'h800000);
        bus.clr_sat = 1'b0;
        chk("sat_min.psum", 32'(bus.psum_out), SAT ? 32'h800000 : 32'h7FFFFF);
        chk("sat_set_wins.flag", 32'(bus.sat_flag), SAT ? 32'h1 : 32'h0);
        compute(2'd0, 1'b0, 8'h01, 24'hFFFFFF);
        chk("sat_umax.psum", 32'(bus.psum_out), SAT ? 32'hFFFFFF : 32'h000000);
        bus.clr_sat = 1'b1;
        step();
        bus.clr_sat = 1'b0;
        chk("sat_clr_idle.flag", 32'(bus.sat_flag), 32'h0);

        // Stall: outputs and weights frozen
        compute(2'd0, 1'b0, 8'h11, 24'd7);
        outs("pre_stall", 24'h18, 1'b1, 8'h11, 1'b1, 8'h01, 1'b0);
        bus.pe_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = i[0];
            bus.act_in   = 8'hA0 + 8'(i);
            bus.psum_in  = 24'h123456;
            bus.w_load   = 1'b1;
            bus.w_in     = 8'hAA;
            bus.w_swap   = 1'b1;
            step();
            outs("stall", 24'h18, 1'b1, 8'h11, 1'b1, 8'h01, 1'b0);
        end
        bus.pe_enable = 1'b1;
        bus.w_load    = 1'b0;
        bus.w_swap    = 1'b0;
        compute(2'd0, 1'b0, 8'h03, 24'd0);
        chk("post_stall.psum", 32'(bus.psum_out), 32'd3);
        bus.w_swap = 1'b1;
        step();
        bus.w_swap = 1'b0;
        compute(2'd0, 1'b0, 8'h03, 24'd0);
        chk("post_stall.shadow", 32'(bus.psum_out), 32'd3);

        // Reset beats a stalled PE
        bus.w_load = 1'b1;
        bus.w_in   = 8'h44;
        compute(2'd0, 1'b0, 8'h22, 24'd1);
        bus.w_load    = 1'b0;
        bus.pe_enable = 1'b0;
        bus.in_valid  = 1'b1;
        reset         = 1'b1;
        step();
        outs("mid_reset", 24'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("mid_reset.sat_flag", 32'(bus.sat_flag), 32'h0);
        reset         = 1'b0;
        bus.pe_enable = 1'b1;
        compute(2'd0, 1'b0, 8'h05, 24'd9);
        chk("post_reset.active", 32'(bus.psum_out), 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_mp_db.md
# pe_mp_db

Multi-precision, double-buffered, weight-stationary processing element for the systolic array. It is the next generation of the array PE, with a parametrised data width, and runs one full-width, two half-width or four quarter-width lane products per cycle, summed into the partial sum. A shadow weight register lets the next tile's weights shift in down the column while the current tile computes. Activations flow left→right and partial sums flow top→bottom, each with a valid bit.

## Interface
Parameters:
- DATA_W, 8, activation/weight width; must be a multiple of 4 and ≥ 4
- PSUM_W, 3*DATA_W, partial-sum width; must be ≥ 2*DATA_W+2

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pe_enable  in  1  global stall; 0 freezes every register
- mode  in  2  precision: 0 = 1×DATA_W, 1 = 2×DATA_W/2, 2 = 4×DATA_W/4, 3 = same as 0
- is_signed  in  1  1 = two's-complement lanes, 0 = unsigned
- in_valid  in  1  act_in/psum_in valid
- act_in  in  DATA_W  activation from the left; lane k = bits [k*L+L-1 : k*L], where L = lane width
- psum_in  in  PSUM_W  partial sum from above
- w_load  in  1  shift w_in into the shadow register
- w_in  in  DATA_W  weight from the PE above (weight chain)
- w_swap  in  1  copy shadow → active weight
- clr_sat  in  1  clear sat_flag
- act_out  out  DATA_W  registered act_in to the right
- act_valid_out  out  1  registered in_valid
- psum_out  out  PSUM_W  accumulated partial sum down
- psum_valid_out  out  1  psum_out valid
- w_out  out  DATA_W  registered shadow weight to the PE below
- w_load_out  out  1  registered w_load
- sat_flag  out  1  sticky saturation indicator

## Operation
- All state updates only on cycles where pe_enable=1 and reset=0. With pe_enable=0, every register holds, including the valids.
- Weight chain, when w_load=1:
  - shadow ← w_in.
  - w_out ← w_in and w_load_out ← 1, so a column of N PEs loads in N cycles.
  - When w_load=0: w_load_out ← 0 and w_out holds.
- Weight swap:
  - w_swap=1 gives active ← shadow.
  - If w_load and w_swap are set in the same cycle, active takes the old shadow and shadow takes w_in.
- Compute, when in_valid=1:
  - psum_out ← psum_in + Σ over lanes of (act lane × active weight lane).
  - Each lane product is 2L bits, sign- or zero-extended per is_signed to PSUM_W before summing.
  - mode and is_signed are sampled every cycle. Changing them takes effect on that cycle's product, with no flush.
  - act_out ← act_in; act_valid_out ← 1; psum_valid_out ← 1.
- When in_valid=0:
  - act_valid_out ← 0 and psum_valid_out ← 0.
  - act_out and psum_out hold.
- The weight path and the compute path are independent; loading and swapping are legal while in_valid=1.
- The product uses the active weight as it was before the edge. A swap never affects the same-cycle product.
- Overflow:
  - Default: the sum wraps modulo 2^PSUM_W.
  - With saturation configured in, see Configuration.
- sat_flag:
  - Set on any saturating cycle.
  - Cleared by clr_sat=1 unless a saturation occurs in that same cycle; set wins.

## Timing
- Compute latency: 1 cycle from in_valid to psum_valid_out/act_valid_out. Throughput: 1 result per cycle.
- Weight chain: 1 cycle per PE hop. A swap is visible to the product of the next cycle.
- Reset values: act_out=0, act_valid_out=0, psum_out=0, psum_valid_out=0, w_out=0, w_load_out=0, sat_flag=0, shadow=0, active=0.
- Reset asserted mid-operation clears all state on that edge and takes priority over pe_enable and every other input. In-flight valids are dropped.

## Configuration
- PE_SAT_EN defined:
  - Accumulation saturates to PSUM_W limits: signed max 2^(PSUM_W-1)-1, signed min -2^(PSUM_W-1), unsigned max 2^PSUM_W-1.
  - sat_flag is implemented as above.
- PE_SAT_EN undefined:
  - Accumulation wraps.
  - sat_flag is tied to 0 and no saturation logic is synthesised.

## Test plan
All scenarios use DATA_W=8, PSUM_W=24.
- Mode 0, signed: active=0xFD (−3), act_in=0x05, psum_in=100 → one cycle later psum_out=85, psum_valid_out=1, act_out=0x05.
- Mode 1, unsigned: weight 0x32, act 0x45, psum_in=0 → 3·4+2·5=22. Mode 1, signed: weight 0xF2, act 0x7F → (−1·7)+(2·−1)=−9, psum_out=0xFFFFF7.
- Mode 2, signed: weight 0xFF, act 0x55 → four lanes (−1)·1 → psum_out=0xFFFFFC. Same stimulus unsigned → 4·3·1=12.
- Double buffer:
  - Active=3, w_load with w_in=2 during compute of act=4 → psum_out=12, w_out=2 and w_load_out=1 one cycle later.
  - Then w_swap; next act=4 → 8.
  - w_load(w_in=5) and w_swap in the same cycle → active=2, shadow=5.
- Saturation, signed: psum_in=0x7FFFFF, product +1.
  - PE_SAT_EN defined → psum_out=0x7FFFFF, sat_flag=1; clr_sat next cycle with no overflow → 0.
  - PE_SAT_EN undefined → psum_out=0x800000, sat_flag=0.
- Stall and reset:
  - pe_enable=0 for 3 cycles with toggling inputs → all outputs frozen.
  - reset=1 mid-stream → all outputs 0 on the next edge, even with pe_enable=0.
